// File: rtl/eth_pkg.sv
// Shared types and helpers for the 10BASE-T Manchester transmitter.
package eth_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NLP   = 2'd1,
        DATA  = 2'd2,
        TPIDL = 2'd3
    } eth_tx_state_t;

    // First half carries the complement of the bit, second half the bit itself.
    function automatic logic manch_level(input logic bit_val, input logic half);
        return half ? bit_val : ~bit_val;
    endfunction

endpackage

// File: rtl/eth_nlp_gen.sv
// Normal Link Pulse timing: idle period counter plus pulse-width counter.
module eth_nlp_gen #(
    parameter int NLP_PERIOD_CYC = 640000,
    parameter int NLP_WIDTH_CYC  = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic nlp_req,
    output logic nlp_active
);

    localparam int PW = $clog2(NLP_PERIOD_CYC);
    localparam int WW = $clog2(NLP_WIDTH_CYC + 1);
    localparam logic [PW-1:0] PER_LAST = PW'(NLP_PERIOD_CYC - 1);
    localparam logic [WW-1:0] WID_LAST = WW'(NLP_WIDTH_CYC - 1);

    logic [PW-1:0] per_cnt_r;
    logic [WW-1:0] wid_cnt_r;
    logic          pulse_r;
    logic          pulse_end_s;

    assign nlp_req     = enable && !pulse_r && (per_cnt_r == PER_LAST);
    assign pulse_end_s = pulse_r && (wid_cnt_r == WID_LAST);
    // High while the pulse continues into the next cycle; low on its final cycle.
    assign nlp_active  = pulse_r && !pulse_end_s;

    // Period counter and pulse-width counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            per_cnt_r <= {PW{1'b0}};
            wid_cnt_r <= {WW{1'b0}};
            pulse_r   <= 1'b0;
        end else begin
            if (clear || pulse_end_s) begin
                per_cnt_r <= {PW{1'b0}};
            end else if (enable && !nlp_req) begin
                per_cnt_r <= per_cnt_r + 1'b1;
            end else begin
                per_cnt_r <= per_cnt_r;
            end

            if (nlp_req) begin
                pulse_r   <= 1'b1;
                wid_cnt_r <= {WW{1'b0}};
            end else if (pulse_end_s) begin
                pulse_r   <= 1'b0;
                wid_cnt_r <= {WW{1'b0}};
            end else if (pulse_r) begin
                wid_cnt_r <= wid_cnt_r + 1'b1;
            end else begin
                wid_cnt_r <= wid_cnt_r;
            end
        end
    end

endmodule

// File: rtl/eth_manchester_tx.sv
// 10BASE-T line transmitter: Manchester-encodes the NRZ frame stream, appends TP_IDL
// at end of frame and emits link pulses while idle.
module eth_manchester_tx
    import eth_pkg::*;
#(
    parameter int HALF_BIT_CYC   = 2,
    parameter int NLP_PERIOD_CYC = 640000,
    parameter int NLP_WIDTH_CYC  = 4,
    parameter int TPIDL_CYC      = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic tx_en,
    input  logic tx_data,
    output logic bit_stb,
    output logic tx_p,
    output logic tx_n,
    output logic busy
);

    localparam int BIT_CYC = 2 * HALF_BIT_CYC;
    localparam int PHW     = $clog2(BIT_CYC);
    localparam int TPW     = $clog2(TPIDL_CYC + 1);
    localparam logic [PHW-1:0] PH_LAST = PHW'(BIT_CYC - 1);
    localparam logic [PHW-1:0] PH_HALF = PHW'(HALF_BIT_CYC);
    localparam logic [TPW-1:0] TP_LAST = TPW'(TPIDL_CYC);

    eth_tx_state_t  state_r, state_d;
    logic [PHW-1:0] ph_r, ph_d;
    logic [TPW-1:0] tp_cnt_r, tp_cnt_d;
    logic           bit_r, bit_d;
    logic           tx_p_d, tx_n_d, stb_d, busy_d;
    logic           level_s;
    logic           nlp_req_s, nlp_active_s, nlp_clear_s, nlp_en_s;

    assign nlp_en_s = (state_r == IDLE) && !tx_en;

    eth_nlp_gen #(
        .NLP_PERIOD_CYC(NLP_PERIOD_CYC),
        .NLP_WIDTH_CYC (NLP_WIDTH_CYC)
    ) u_nlp (
        .clk       (clk),
        .reset     (reset),
        .clear     (nlp_clear_s),
        .enable    (nlp_en_s),
        .nlp_req   (nlp_req_s),
        .nlp_active(nlp_active_s)
    );

    // Next state and next output values; outputs lead the phase counter by one cycle.
    always_comb begin
        state_d     = state_r;
        ph_d        = ph_r;
        tp_cnt_d    = tp_cnt_r;
        bit_d       = bit_r;
        tx_p_d      = 1'b0;
        tx_n_d      = 1'b0;
        stb_d       = 1'b0;
        nlp_clear_s = 1'b0;
        level_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (tx_en) begin
                    state_d = DATA;
                    ph_d    = {PHW{1'b0}};
                    stb_d   = 1'b1;
                end else if (nlp_req_s) begin
                    state_d = NLP;
                    tx_p_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            NLP: begin
                if (nlp_active_s) begin
                    tx_p_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (ph_r == {PHW{1'b0}}) begin
                    bit_d   = tx_data;
                    level_s = manch_level(tx_data, 1'b0);
                    ph_d    = ph_r + 1'b1;
                end else if (ph_r == PH_LAST) begin
                    level_s = manch_level(bit_r, 1'b1);
                    // Bit boundary: the only point where tx_en is looked at.
                    if (tx_en) begin
                        ph_d  = {PHW{1'b0}};
                        stb_d = 1'b1;
                    end else begin
                        state_d  = TPIDL;
                        tp_cnt_d = {TPW{1'b0}};
                    end
                end else begin
                    level_s = manch_level(bit_r, ph_r >= PH_HALF);
                    ph_d    = ph_r + 1'b1;
                end
                tx_p_d = level_s;
                tx_n_d = ~level_s;
            end
            TPIDL: begin
                if (tp_cnt_r == TP_LAST) begin
                    state_d     = IDLE;
                    nlp_clear_s = 1'b1;
                end else begin
                    tx_p_d   = 1'b1;
                    tp_cnt_d = tp_cnt_r + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == DATA) || (state_d == TPIDL);
    end

    // State, counters and registered line outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= IDLE;
            ph_r     <= {PHW{1'b0}};
            tp_cnt_r <= {TPW{1'b0}};
            bit_r    <= 1'b0;
            tx_p     <= 1'b0;
            tx_n     <= 1'b0;
            bit_stb  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state_r  <= state_d;
            ph_r     <= ph_d;
            tp_cnt_r <= tp_cnt_d;
            bit_r    <= bit_d;
            tx_p     <= tx_p_d;
            tx_n     <= tx_n_d;
            bit_stb  <= stb_d;
            busy     <= busy_d;
        end
    end

endmodule
